datapath_controller: RTL
========================

Name: datapath_controller

Overview:
Sequencer that sits directly upstream of the 16-bit accumulator DataPath and drives all of its control inputs.
- Accepts one instruction at a time (opcode plus 16-bit operand) over a valid/ready handshake.
- Decodes it and drives the DataPath's one-hot control strobes, alu_on_bus, ld_AC and DataInput with correct timing, including a multi-cycle multiply.
- Reports completion, an operation count and an illegal-opcode error.

Parameters:
DATA_W, 16, width of the operand and of DataInput
MUL_CYCLES, 2, cycles Multiply_AC is held (≥1)
CNT_W, 8, width of op_count

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  controller can accept
instr_op  in  4  opcode
instr_data  in  DATA_W  operand
DataInput  out  DATA_W  operand to DataPath
Reset_AC  out  1  DataPath clear strobe
Increment_AC  out  1  increment strobe
Swaprightleft_AC  out  1  byte-swap strobe
ShiftRight_AC  out  1  shift-right strobe
Add_Input_AC  out  1  add-operand strobe
Complement_AC  out  1  complement strobe
Multiply_AC  out  1  multiply strobe
alu_on_bus  out  1  ALU result drives bus
ld_AC  out  1  AC load enable
busy  out  1  instruction in progress
done  out  1  one-cycle completion pulse
illegal_op  out  1  sticky illegal-opcode flag
op_count  out  CNT_W  legal instructions completed

Behaviour:
- Clock and reset: single clock (clk), rising edge. Reset is asynchronous and active-low (reset_n).
- Reset values:
  - State is IDLE.
  - DataInput = 0, all strobes = 0, alu_on_bus = 0, ld_AC = 0.
  - busy = 0, done = 0, illegal_op = 0, op_count = 0.
  - instr_ready = 1 (combinational: state == IDLE).
  - No capture while reset_n is low.
- Opcodes:
  - 0 NOP, 1 RESET, 2 INC, 3 SWAP, 4 SHR, 5 ADD, 6 CMP, 7 MUL.
  - 8–15 are illegal.
- State IDLE:
  - instr_ready = 1, busy = 0.
  - Handshake occurs when instr_valid && instr_ready at a rising edge; instr_op and instr_data are registered.
  - Legal 1–6 go to EXEC; 7 goes to MUL; NOP goes to DONE.
  - Illegal opcodes go to DONE and set illegal_op.
- State EXEC (exactly 1 cycle):
  - Exactly one strobe, matching the opcode, is high.
  - alu_on_bus = 1, ld_AC = 1.
  - DataInput = captured operand.
  - Next state is DONE.
- State MUL (MUL_CYCLES cycles, internal counter):
  - Multiply_AC = 1 and alu_on_bus = 1 throughout.
  - ld_AC = 1 only in the final MUL cycle; DataInput = operand throughout.
  - Next state is DONE.
- State DONE (1 cycle):
  - done = 1, all strobes, alu_on_bus and ld_AC = 0.
  - op_count increments only for legal opcodes, including NOP; wraps from max to 0.
  - Next state is IDLE.
- busy = 1 in EXEC, MUL and DONE.
- DataInput holds its last captured value outside EXEC/MUL; it changes only on handshake.
- Strobe exclusivity: at most one of the seven strobes is high in any cycle; all strobes are 0 in IDLE and DONE.
- Latency (handshake at edge k):
  - Single-cycle op: strobe in cycle k+1, done in cycle k+2, ready again in k+3.
  - MUL: strobe in cycles k+1..k+MUL_CYCLES, done in cycle k+MUL_CYCLES+1.
  - NOP or illegal: done in cycle k+1.
- Back-to-back: instr_valid held high is accepted on the first IDLE edge after DONE. instr_valid while not ready is ignored, not queued.
- illegal_op is cleared only by reset. An illegal instruction drives no strobe and does not increment op_count.
- MUL_CYCLES = 1: MUL timing is identical to EXEC.
- Reset mid-operation (any state): outputs go to reset values immediately (asynchronously); the in-flight instruction is discarded with no done pulse.

Test Plan:
- Release reset; instr_op=2, operand 0, single handshake → Increment_AC, alu_on_bus, ld_AC high for exactly 1 cycle at k+1; done at k+2; op_count=1; instr_ready low for k+1..k+2.
- instr_op=5, instr_data=16'hF00F → DataInput=16'hF00F with Add_Input_AC at k+1; DataInput still 16'hF00F after DONE.
- instr_op=7, instr_data=16'h0200, MUL_CYCLES=2 → Multiply_AC high at k+1 and k+2, ld_AC high only at k+2, done at k+3.
- instr_op=4'hB → no strobe ever asserted; done at k+1; illegal_op=1 and stays 1 across a following legal INC; op_count unchanged by the illegal op.
- Stream RESET, INC, SWAP, SHR, ADD, CMP with instr_valid held high → each strobe fires once, in order, 3 cycles apart; op_count=6; never two strobes high in the same cycle.
- Assert reset_n low during the second MUL cycle → all strobes, ld_AC and busy drop immediately; no done pulse; op_count=0; instr_ready=1 after release.

Source files
------------

// File: rtl/datapath_controller_if.sv
// Instruction handshake bundle between an issuing master and the datapath_controller.
// Latency: none, wires only.
// Backpressure: the master holds instr_op/instr_data while instr_valid is high and instr_ready is low.
//   instr_valid : master -> slave, instruction present
//   instr_ready : slave -> master, controller can accept
//   instr_op    : master -> slave, 4-bit opcode
//   instr_data  : master -> slave, DATA_W-bit operand
interface datapath_controller_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_op;
  logic [DATA_W-1:0] instr_data;

  modport master (output instr_valid, output instr_op, output instr_data, input instr_ready);
  modport slave  (input instr_valid, input instr_op, input instr_data, output instr_ready);
endinterface

// File: rtl/datapath_controller.sv
// Sequencer that decodes one instruction at a time and drives the accumulator DataPath controls.
// Latency: single-cycle ops strobe at k+1 and report done at k+2; MUL strobes k+1..k+MUL_CYCLES.
// Backpressure: instr_ready is high only in IDLE; valid while not ready is ignored, never queued.
//   clk, reset_n : clock, asynchronous active-low reset
//   cmd          : instruction handshake (slave side)
//   DataInput    : captured operand, changes only on handshake
//   *_AC strobes : one-hot DataPath operation strobes
//   alu_on_bus, ld_AC : ALU result onto bus, accumulator load enable
//   busy, done, illegal_op, op_count : status
module datapath_controller #(
  parameter int DATA_W     = 16,
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  datapath_controller_if.slave cmd,
  output logic [DATA_W-1:0] DataInput,
  output logic              Reset_AC,
  output logic              Increment_AC,
  output logic              Swaprightleft_AC,
  output logic              ShiftRight_AC,
  output logic              Add_Input_AC,
  output logic              Complement_AC,
  output logic              Multiply_AC,
  output logic              alu_on_bus,
  output logic              ld_AC,
  output logic              busy,
  output logic              done,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  op_count
);

  localparam int MC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MC_W-1:0] MUL_LAST = MC_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      op_q;
  logic [MC_W-1:0] mul_cnt;
  logic            accept;
  logic            mul_last;

  assign cmd.instr_ready = (state == IDLE);
  assign accept          = cmd.instr_valid && (state == IDLE);
  assign mul_last        = (mul_cnt == MUL_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_q       <= 4'd0;
      DataInput  <= '0;
      mul_cnt    <= '0;
      illegal_op <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q      <= cmd.instr_op;
        DataInput <= cmd.instr_data;
        if (cmd.instr_op[3]) illegal_op <= 1'b1;
      end
      // Counter runs only while in MUL and is cleared everywhere else,
      // so every multiply starts counting from zero.
      if (state == MUL) mul_cnt <= mul_cnt + 1'b1;
      else              mul_cnt <= '0;
      // Opcodes 8..15 have bit 3 set; everything else, NOP included, counts.
      if (state == DONE && !op_q[3]) op_count <= op_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd.instr_op[3] || cmd.instr_op == 4'd0) state_nxt = DONE;
          else if (cmd.instr_op == 4'd7)               state_nxt = MUL;
          else                                         state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = DONE;
      MUL:     if (mul_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from the registered state only, so an asynchronous
  // reset forces them to their idle values immediately.
  always_comb begin
    Reset_AC         = 1'b0;
    Increment_AC     = 1'b0;
    Swaprightleft_AC = 1'b0;
    ShiftRight_AC    = 1'b0;
    Add_Input_AC     = 1'b0;
    Complement_AC    = 1'b0;
    Multiply_AC      = 1'b0;
    alu_on_bus       = 1'b0;
    ld_AC            = 1'b0;
    busy             = (state != IDLE);
    done             = (state == DONE);
    case (state)
      EXEC: begin
        alu_on_bus = 1'b1;
        ld_AC      = 1'b1;
        case (op_q)
          4'd1:    Reset_AC         = 1'b1;
          4'd2:    Increment_AC     = 1'b1;
          4'd3:    Swaprightleft_AC = 1'b1;
          4'd4:    ShiftRight_AC    = 1'b1;
          4'd5:    Add_Input_AC     = 1'b1;
          4'd6:    Complement_AC    = 1'b1;
          default: ;
        endcase
      end
      MUL: begin
        Multiply_AC = 1'b1;
        alu_on_bus  = 1'b1;
        ld_AC       = mul_last;
      end
      default: ;
    endcase
  end

endmodule
